// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: control and status bundle of the parametrised LFSR.
// master drives enable/load/seed_in, slave returns state and status.
interface lfsr_gen_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = WIDTH
);
   logic             enable;
   logic             load;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] value;
   logic             wrap;
   logic [CNT_W-1:0] period;
   logic             lockup;

   modport master (
      output enable, load, seed_in,
      input  value, wrap, period, lockup
   );

   modport slave (
      input  enable, load, seed_in,
      output value, wrap, period, lockup
   );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci/Galois LFSR with multi-step advance, seed load,
// all-zero recovery and a period counter that pulses wrap on return.
module lfsr_gen #(
   parameter int               WIDTH  = 8,
   parameter logic [WIDTH-1:0] TAPS   = WIDTH'(8'hB8),
   parameter int               GALOIS = 0,
   parameter int               STEPS  = 1,
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(1),
   parameter int               CNT_W  = WIDTH
) (
   input  logic       clk,
   input  logic       reset,
   lfsr_gen_if.slave  bus
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] seed_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] period_q;
   logic             wrap_q;

   logic [WIDTH-1:0] nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic             lock;

   assign lock = (value_q == '0);

   // Saturating successor of the enabled-cycle counter.
   assign cnt_inc = (&count_q) ? count_q : count_q + 1'b1;

   // Unrolled STEPS single-steps of the selected topology.
   always_comb begin
      nxt = value_q;
      for (int i = 0; i < STEPS; i++) begin
         if (GALOIS != 0)
            nxt = (nxt >> 1) ^ (nxt[0] ? TAPS : '0);
         else
            nxt = {nxt[WIDTH-2:0], ^(nxt & TAPS)};
      end
   end

   // State, seed, counter and wrap update in priority order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q  <= SEED;
         seed_q   <= SEED;
         count_q  <= '0;
         period_q <= '0;
         wrap_q   <= 1'b0;
      end else if (bus.load) begin
         value_q <= bus.seed_in;
         seed_q  <= bus.seed_in;
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else if (bus.enable) begin
         if (lock) begin
            value_q <= SEED;
            seed_q  <= SEED;
            count_q <= '0;
            wrap_q  <= 1'b0;
         end else begin
            value_q <= nxt;
            if (nxt == seed_q) begin
               wrap_q   <= 1'b1;
               period_q <= cnt_inc;
               count_q  <= '0;
            end else begin
               wrap_q  <= 1'b0;
               count_q <= cnt_inc;
            end
         end
      end else begin
         wrap_q <= 1'b0;
      end
   end

   assign bus.value  = value_q;
   assign bus.wrap   = wrap_q;
   assign bus.period = period_q;
   assign bus.lockup = lock;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: three lfsr_gen configurations (default, Galois, 3-step)
// checked every cycle against a behavioural model plus literal vectors.
module tb_lfsr_gen;

   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   go = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   lfsr_gen_if #(.WIDTH(8), .CNT_W(8)) ifa ();
   lfsr_gen_if #(.WIDTH(8), .CNT_W(8)) ifb ();
   lfsr_gen_if #(.WIDTH(8), .CNT_W(8)) ifc ();

   lfsr_gen dut_a (.clk(clk), .reset(reset), .bus(ifa));
   lfsr_gen #(.GALOIS(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
   lfsr_gen #(.STEPS(3)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

   logic       en [3];
   logic       ld [3];
   logic [7:0] sd [3];
   logic [7:0] val [3];
   logic [7:0] per [3];
   logic       wrp [3];
   logic       lck [3];

   assign ifa.enable = en[0];
   assign ifa.load = ld[0];
   assign ifa.seed_in = sd[0];
   assign ifb.enable = en[1];
   assign ifb.load = ld[1];
   assign ifb.seed_in = sd[1];
   assign ifc.enable = en[2];
   assign ifc.load = ld[2];
   assign ifc.seed_in = sd[2];

   assign val[0] = ifa.value;
   assign val[1] = ifb.value;
   assign val[2] = ifc.value;
   assign per[0] = ifa.period;
   assign per[1] = ifb.period;
   assign per[2] = ifc.period;
   assign wrp[0] = ifa.wrap;
   assign wrp[1] = ifb.wrap;
   assign wrp[2] = ifc.wrap;
   assign lck[0] = ifa.lockup;
   assign lck[1] = ifb.lockup;
   assign lck[2] = ifc.lockup;

   int unsigned m_val [3];
   int unsigned m_seed [3];
   int unsigned m_cnt [3];
   int unsigned m_per [3];
   int unsigned m_wrap [3];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Arithmetic form of the 8-bit, taps B8 recurrence.
   function automatic int unsigned adv(input int unsigned s,
                                       input int d);
      int unsigned t;
      int n;
      t = s;
      n = (d == 2) ? 3 : 1;
      for (int k = 0; k < n; k++) begin
         if (d == 1)
            t = (t % 2 == 1) ? ((t / 2) ^ 32'hB8) : (t / 2);
         else
            t = ((t * 2) % 256) + ($countones(t & 32'hB8) % 2);
      end
      return t;
   endfunction

   function automatic int unsigned sat(input int unsigned c);
      return (c >= 255) ? 255 : c + 1;
   endfunction

   // Behavioural model of all three instances.
   always @(posedge clk or posedge reset) begin
      int unsigned nv;
      for (int d = 0; d < 3; d++) begin
         if (reset) begin
            m_val[d] = 1;
            m_seed[d] = 1;
            m_cnt[d] = 0;
            m_per[d] = 0;
            m_wrap[d] = 0;
         end else if (ld[d]) begin
            m_val[d] = sd[d];
            m_seed[d] = sd[d];
            m_cnt[d] = 0;
            m_wrap[d] = 0;
         end else if (en[d]) begin
            if (m_val[d] == 0) begin
               m_val[d] = 1;
               m_seed[d] = 1;
               m_cnt[d] = 0;
               m_wrap[d] = 0;
            end else begin
               nv = adv(m_val[d], d);
               m_val[d] = nv;
               if (nv == m_seed[d]) begin
                  m_wrap[d] = 1;
                  m_per[d] = sat(m_cnt[d]);
                  m_cnt[d] = 0;
               end else begin
                  m_wrap[d] = 0;
                  m_cnt[d] = sat(m_cnt[d]);
               end
            end
         end else begin
            m_wrap[d] = 0;
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (go) begin
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("m%0d_value", d), 32'(val[d]), m_val[d]);
            chk($sformatf("m%0d_wrap", d), 32'(wrp[d]), m_wrap[d]);
            chk($sformatf("m%0d_period", d), 32'(per[d]), m_per[d]);
            chk($sformatf("m%0d_lockup", d), 32'(lck[d]),
                (m_val[d] == 0) ? 32'd1 : 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

   logic [7:0] fib_seq [8];
   logic [7:0] gal_seq [5];

   initial begin
      fib_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
      gal_seq = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
      for (int d = 0; d < 3; d++) begin
         en[d] = 0;
         ld[d] = 0;
         sd[d] = 8'h00;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      go = 1'b1;

      chk("rst_value", 32'(val[0]), 32'h01);
      chk("rst_period", 32'(per[0]), 32'h0);
      chk("rst_wrap", 32'(wrp[0]), 32'h0);
      chk("rst_lockup", 32'(lck[0]), 32'h0);

      en[0] = 1;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("fib_seq%0d", i), 32'(val[0]), 32'(fib_seq[i]));
         chk("fib_wrap0", 32'(wrp[0]), 32'h0);
      end
      repeat (248) @(negedge clk);
      chk("fib_ret_value", 32'(val[0]), 32'h01);
      chk("fib_ret_wrap", 32'(wrp[0]), 32'h1);
      chk("fib_period", 32'(per[0]), 32'd255);
      @(negedge clk);
      chk("fib_after_value", 32'(val[0]), 32'h02);
      chk("fib_after_wrap", 32'(wrp[0]), 32'h0);
      en[0] = 0;

      ld[1] = 1;
      sd[1] = 8'h01;
      @(negedge clk);
      ld[1] = 0;
      en[1] = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("gal_seq%0d", i), 32'(val[1]), 32'(gal_seq[i]));
      end
      repeat (250) @(negedge clk);
      chk("gal_ret_value", 32'(val[1]), 32'h01);
      chk("gal_wrap", 32'(wrp[1]), 32'h1);
      chk("gal_period", 32'(per[1]), 32'd255);
      en[1] = 0;

      en[2] = 1;
      @(negedge clk);
      chk("s3_first", 32'(val[2]), 32'h08);
      en[2] = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s3_hold_value", 32'(val[2]), 32'h08);
         chk("s3_hold_wrap", 32'(wrp[2]), 32'h0);
      end
      en[2] = 1;
      repeat (84) @(negedge clk);
      chk("s3_ret_value", 32'(val[2]), 32'h01);
      chk("s3_wrap", 32'(wrp[2]), 32'h1);
      chk("s3_period", 32'(per[2]), 32'd85);
      en[2] = 0;

      ld[0] = 1;
      sd[0] = 8'h00;
      @(negedge clk);
      ld[0] = 0;
      for (int i = 0; i < 3; i++) begin
         chk("lk_value", 32'(val[0]), 32'h00);
         chk("lk_lockup", 32'(lck[0]), 32'h1);
         @(negedge clk);
      end
      en[0] = 1;
      @(negedge clk);
      chk("rec_value", 32'(val[0]), 32'h01);
      chk("rec_lockup", 32'(lck[0]), 32'h0);
      chk("rec_wrap", 32'(wrp[0]), 32'h0);
      @(negedge clk);
      chk("rec_next", 32'(val[0]), 32'h02);
      chk("rec_next_wrap", 32'(wrp[0]), 32'h0);
      ld[0] = 1;
      sd[0] = 8'h5A;
      @(negedge clk);
      chk("ld_en_value", 32'(val[0]), 32'h5A);
      ld[0] = 0;

      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_value", 32'(val[0]), 32'h01);
      chk("arst_period", 32'(per[0]), 32'h0);
      chk("arst_wrap", 32'(wrp[0]), 32'h0);
      chk("arst_c_period", 32'(per[2]), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("arst_seq1", 32'(val[0]), 32'h02);
      @(negedge clk);
      chk("arst_seq2", 32'(val[0]), 32'h04);
      en[0] = 0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the team's fixed 8-bit LFSR.
- Adds:
  - configurable width and taps
  - Fibonacci or Galois topology
  - multiple steps per clock
  - run-time seed load
  - all-zero lock-up detection with auto-recovery
  - a period counter with a wrap pulse
- Used as a pattern/noise source and as a self-checking sequence generator in test designs.

Parameters:
- WIDTH, 8: state width, legal 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits; bit i set means state bit i is tapped.
- GALOIS, 0: 0 selects Fibonacci (left shift), 1 selects Galois (right shift).
- STEPS, 1: single-steps applied per enabled cycle, legal 1..8.
- SEED, 1: reset and recovery state; must be non-zero.
- CNT_W, WIDTH: period counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  advance state by STEPS single-steps this cycle.
- load  in  1  load seed_in; priority over enable.
- seed_in  in  WIDTH  seed value for load.
- value  out  WIDTH  current LFSR state (registered).
- wrap  out  1  one-cycle pulse: value has just returned to the active seed.
- period  out  CNT_W  enabled cycles taken by the last completed cycle.
- lockup  out  1  high while value == 0.

Behaviour:
- Reset (async, active-high):
  - value = SEED; internal seed_reg = SEED; count = 0; period = 0; wrap = 0.
  - lockup = 0, since SEED is non-zero.
- Fibonacci single-step: fb = XOR-reduce(s & TAPS); s' = {s[WIDTH-2:0], fb}.
- Galois single-step: s' = (s >> 1) ^ (s[0] ? TAPS : 0).
- An enabled cycle applies the single-step STEPS times, combinationally unrolled; value updates on that clock edge (latency 1).
- Priority, highest first: reset, load, lock-up recovery, enable step, hold.
- Load:
  - value <= seed_in; seed_reg <= seed_in; count <= 0; wrap <= 0.
  - period is held.
  - enable is ignored in that cycle.
- Lock-up:
  - lockup is combinational (value == 0).
  - If lockup && enable && !load: value <= SEED; seed_reg <= SEED; count <= 0; wrap <= 0.
  - Never steps an all-zero state.
- Enable step, when not locked up:
  - If next value == seed_reg: wrap <= 1; period <= count + 1; count <= 0.
  - Otherwise: wrap <= 0; count <= count + 1, saturating at all ones.
  - On saturation, period is only updated by a later wrap.
- enable low (and no load): value, count, period and seed_reg hold; wrap <= 0. wrap is therefore never high for two consecutive cycles unless the period is 1.
- A wrap needs no special reseed: the sequence continues naturally from seed_reg.
- Reset mid-operation: all state returns to reset values immediately; no pending wrap survives.
- Non-primitive TAPS is legal: the shorter cycle is reported via period.
- STEPS > 1: period = (single-step period) / gcd(STEPS, single-step period).

Test Plan:
1. Defaults, reset pulse then enable=1:
   - value sequence 01,02,04,08,11,23,47,8E on successive cycles.
   - wrap=0 throughout this sequence.
2. Defaults, 255 enabled cycles after reset:
   - value returns to 01 with wrap=1 for exactly one cycle; period=255.
   - Next cycle value=02, wrap=0.
3. GALOIS=1, TAPS=8'hB8, seed 01 loaded:
   - value sequence B8,5C,2E,17,B3.
   - After 255 enabled cycles: wrap=1, period=255.
4. STEPS=3, defaults otherwise:
   - First enabled cycle gives 08.
   - period=85 after first wrap.
   - enable toggled low mid-run: value and count hold, wrap stays 0.
5. load=1 with seed_in=00:
   - value=00, lockup=1, held while enable=0.
   - First enable cycle: value=01, lockup=0, count restarts; no wrap.
   - load and enable together with seed_in=5A: value=5A, not stepped.
6. Async reset asserted between clock edges mid-run:
   - value=01, period=0, wrap=0 immediately, before the next clock edge.
   - Sequence restarts cleanly after release.
